exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception/interrupt request controller directly upstream of CP0.
- Collects trap requests from decode (syscall, break, teq-taken, eret) and latched external interrupt lines.
- Qualifies requests against CP0 status, prioritises them, and drives CP0's exception, eret and 5-bit cause inputs as registered one-cycle pulses.
- Also drives the PC-select strobe that loads CP0 exc_addr into the PC.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..8).
- IRQ_MASK_BASE, 8, status bit index of the mask bit for irq[0]; irq[k] is masked by status[IRQ_MASK_BASE+k].

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low (asserted when 0, sampled on the rising edge of clk).
- syscall_req  input  1  decode holds a SYSCALL.
- break_req  input  1  decode holds a BREAK.
- teq_req  input  1  decode holds a TEQ whose compare is true.
- eret_req  input  1  decode holds an ERET.
- ext_irq  input  NUM_IRQ  level-sensitive external interrupt lines.
- status  input  32  CP0 status register.
- exception  output  1  to CP0 exception input.
- eret  output  1  to CP0 eret input.
- cause  output  5  to CP0 cause input.
- pc_exc_sel  output  1  PC mux selects CP0 exc_addr this cycle.
- irq_pending  output  NUM_IRQ  sticky pending-interrupt register.

Behaviour:
- Reset (rst==0 at a rising edge):
  - exception=0, eret=0, cause=0, pc_exc_sel=0, irq_pending=0, state=IDLE.
  - Reset mid-pulse aborts the pulse that same edge.
- Enables:
  - Global enable: status[0].
  - Per-source enables: syscall status[1], break status[2], teq status[3], irq[k] status[IRQ_MASK_BASE+k].
  - A source is eligible only if status[0] and its own bit are both 1.
- Pending interrupts:
  - irq_pending[k] is set on any edge where the sampled ext_irq[k]==1.
  - It is cleared on the edge that takes irq k.
  - If set and clear hit the same edge, set wins.
- Cause codes:
  - irq 5'b00000, syscall 5'b01000, break 5'b01001, teq 5'b01101.
  - cause holds its last value when no pulse is issued.
- Priority, highest first: eret_req (ignores enables), teq, break, syscall, lowest-index eligible pending irq.
- State machine, 2-bit:
  - IDLE: if any eligible request exists, go to EXC on the next edge.
  - EXC: exception=1, pc_exc_sel=1, cause=selected code for exactly one cycle, then go to HANDLER.
  - HANDLER: all trap and irq requests are ignored; only eret_req is acted on, going to RET.
  - RET: eret=1, exception=1 (CP0 restores status only when both are high), pc_exc_sel=1 for one cycle, then go to IDLE.
  - eret_req in IDLE also goes to RET, so the kernel can return without a taken trap.
- Latency: a request sampled at edge N gives a pulse during cycle N to N+1. CP0 captures it on the intervening falling edge.
- Simultaneous requests: exactly one is taken, per priority.
  - A lower-priority irq stays pending.
  - A trap request not taken is dropped, because the PC is redirected.
- Requests present during EXC or RET are ignored.
- Status changes take effect on the next evaluation; there is no internal copy of status.

Optional Feature:
- Macro: EXC_IRQ_SYNC_EN.
- Defined: ext_irq passes through a 2-flop synchroniser before pending capture, adding 2 cycles of irq latency. The synchroniser flops reset to 0.
- Undefined: ext_irq is sampled directly into irq_pending.
- Trap timing is identical in both builds.

Decomposition:
- Shared header exc_defs: cause codes, status bit indices (IE=0, SYS=1, BRK=2, TEQ=3), state encodings (IDLE=0, EXC=1, HANDLER=2, RET=3).
- Sub-module irq_sync: per-bit 2-flop synchroniser with parameter WIDTH. It is instantiated only under EXC_IRQ_SYNC_EN.

Test Plan:
- Reset with rst=0 for 2 cycles, all requests high → all outputs 0 and state IDLE. After release with status=0x0000000f: the first trap pulse is teq, cause=5'b01101.
- status=0xf, syscall_req high for 1 cycle → next cycle exception=1, pc_exc_sel=1, cause=5'b01000 for exactly 1 cycle, eret=0. A second syscall in HANDLER produces no pulse.
- status=0xf, teq_req, break_req and syscall_req together → cause=5'b01101 only. After eret_req, one cycle with eret=1 and exception=1, then IDLE.
- status=0x00000f01 (IE plus irq0..3 masks set), ext_irq=4'b0110 → irq_pending=0110 and cause=0. irq_pending becomes 0100 after the take, and irq2 is taken after the next eret.
- status=0x0000000e (IE=0), syscall_req and ext_irq[0] high → no exception, irq_pending[0]=1 is retained. Setting status to 0x101 then gives a pulse with cause=0.
- With EXC_IRQ_SYNC_EN, a 1-cycle ext_irq[1] pulse → irq_pending[1] sets 3 edges after the pulse rather than 1. Without the macro → 1 edge.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl shared definitions: state encodings,
// CP0 status bit indices and cause codes.
package exc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXC     = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RET     = 2'd3
  } exc_state_e;

  localparam int unsigned SB_IE  = 0;
  localparam int unsigned SB_SYS = 1;
  localparam int unsigned SB_BRK = 2;
  localparam int unsigned SB_TEQ = 3;

  localparam logic [4:0] CAUSE_INT = 5'b00000;
  localparam logic [4:0] CAUSE_SYS = 5'b01000;
  localparam logic [4:0] CAUSE_BRK = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ = 5'b01101;

endpackage

// File: rtl/exc_ctrl_irq_sync.sv
// Per-bit two-flop synchroniser for external interrupt lines.
// Flops clear to 0 on synchronous active-low reset.
module exc_ctrl_irq_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/exc_ctrl.sv
// Trap/interrupt request controller feeding CP0.
// Define EXC_IRQ_SYNC_EN to synchronise ext_irq before capture.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int NUM_IRQ       = 4,
  parameter int IRQ_MASK_BASE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               syscall_req,
  input  logic               break_req,
  input  logic               teq_req,
  input  logic               eret_req,
  input  logic [NUM_IRQ-1:0] ext_irq,
  input  logic [31:0]        status,
  output logic               exception,
  output logic               eret,
  output logic [4:0]         cause,
  output logic               pc_exc_sel,
  output logic [NUM_IRQ-1:0] irq_pending
);

  exc_state_e         state_q, state_d;
  logic [4:0]         cause_q, cause_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] irq_smp;
  logic [NUM_IRQ-1:0] irq_elig, irq_pick, irq_clr;
  logic               ie, sys_ok, brk_ok, teq_ok;
  logic               any_trap, any_irq;
  logic               unused_status;

`ifdef EXC_IRQ_SYNC_EN
  exc_ctrl_irq_sync #(
    .WIDTH(NUM_IRQ)
  ) u_irq_sync (
    .clk(clk),
    .rst(rst),
    .d_i(ext_irq),
    .q_o(irq_smp)
  );
`else
  assign irq_smp = ext_irq;
`endif

  assign unused_status = ^status;

  assign ie       = status[SB_IE];
  assign sys_ok   = ie & status[SB_SYS] & syscall_req;
  assign brk_ok   = ie & status[SB_BRK] & break_req;
  assign teq_ok   = ie & status[SB_TEQ] & teq_req;
  assign any_trap = sys_ok | brk_ok | teq_ok;

  assign irq_elig = pend_q
                  & status[IRQ_MASK_BASE +: NUM_IRQ]
                  & {NUM_IRQ{ie}};
  assign any_irq  = |irq_elig;
  // isolate lowest set bit
  assign irq_pick = irq_elig & (~irq_elig + NUM_IRQ'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    irq_clr = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (eret_req) begin
          state_d = ST_RET;
        end else if (teq_ok) begin
          state_d = ST_EXC;
          cause_d = CAUSE_TEQ;
        end else if (brk_ok) begin
          state_d = ST_EXC;
          cause_d = CAUSE_BRK;
        end else if (sys_ok) begin
          state_d = ST_EXC;
          cause_d = CAUSE_SYS;
        end else if (any_irq) begin
          state_d = ST_EXC;
          cause_d = CAUSE_INT;
          irq_clr = irq_pick;
        end
      end
      ST_EXC:     state_d = ST_HANDLER;
      ST_HANDLER: if (eret_req) state_d = ST_RET;
      ST_RET:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // a new sample wins over the take-clear
    pend_d = (pend_q & ~irq_clr) | irq_smp;
  end

  always_comb begin
    exception  = (state_q == ST_EXC) || (state_q == ST_RET);
    pc_exc_sel = exception;
    eret       = (state_q == ST_RET);
  end

  assign cause       = cause_q;
  assign irq_pending = pend_q;

  logic unused_trap;
  assign unused_trap = any_trap;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: expected outputs queued
// with each stimulus cycle and compared after the edge.
module tb_exc_ctrl;

`ifdef EXC_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        syscall_req = 1'b0;
  logic        break_req = 1'b0;
  logic        teq_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [3:0]  ext_irq = '0;
  logic [31:0] status = '0;
  logic        exception, eret, pc_exc_sel;
  logic [4:0]  cause;
  logic [3:0]  irq_pending;

  typedef struct packed {
    logic       exc;
    logic       ert;
    logic [4:0] cause;
    logic [3:0] pend;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  exc_ctrl #(
    .NUM_IRQ(4),
    .IRQ_MASK_BASE(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .syscall_req(syscall_req),
    .break_req(break_req),
    .teq_req(teq_req),
    .eret_req(eret_req),
    .ext_irq(ext_irq),
    .status(status),
    .exception(exception),
    .eret(eret),
    .cause(cause),
    .pc_exc_sel(pc_exc_sel),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r,
                     input logic sc, br, tq, er,
                     input logic [3:0] irq,
                     input logic [31:0] st,
                     input logic e_exc, e_ert,
                     input logic [4:0] e_cause,
                     input logic [3:0] e_pend,
                     input string tag);
    exp_t g;
    rst         = r;
    syscall_req = sc;
    break_req   = br;
    teq_req     = tq;
    eret_req    = er;
    ext_irq     = irq;
    status      = st;
    sb_q.push_back({e_exc, e_ert, e_cause, e_pend});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      g = sb_q.pop_front();
      chk({tag, ".exc"}, {31'd0, exception}, {31'd0, g.exc});
      chk({tag, ".pc"}, {31'd0, pc_exc_sel}, {31'd0, g.exc});
      chk({tag, ".eret"}, {31'd0, eret}, {31'd0, g.ert});
      chk({tag, ".cause"}, {27'd0, cause}, {27'd0, g.cause});
      chk({tag, ".pend"}, {28'd0, irq_pending}, {28'd0, g.pend});
    end
  endtask

  initial begin
    cyc(0,1,1,1,1,4'hf,32'hf, 0,0,5'h00,4'h0,"rst0");
    cyc(0,1,1,1,1,4'hf,32'hf, 0,0,5'h00,4'h0,"rst1");
    cyc(1,1,1,1,0,4'h0,32'hf, 1,0,5'h0d,4'h0,"teq_first");
    cyc(1,0,0,0,0,4'h0,32'hf, 0,0,5'h0d,4'h0,"teq_hnd");
    cyc(1,0,0,0,1,4'h0,32'hf, 1,1,5'h0d,4'h0,"teq_ret");
    cyc(1,0,0,0,0,4'h0,32'hf, 0,0,5'h0d,4'h0,"teq_idle");

    cyc(1,1,0,0,0,4'h0,32'hf, 1,0,5'h08,4'h0,"sys");
    cyc(1,1,0,0,0,4'h0,32'hf, 0,0,5'h08,4'h0,"sys_exc_ign");
    cyc(1,1,0,0,0,4'h0,32'hf, 0,0,5'h08,4'h0,"sys_hnd_ign");
    cyc(1,0,0,0,1,4'h0,32'hf, 1,1,5'h08,4'h0,"sys_ret");
    cyc(1,0,0,0,0,4'h0,32'hf, 0,0,5'h08,4'h0,"sys_idle");

    cyc(1,1,1,1,0,4'h0,32'hf, 1,0,5'h0d,4'h0,"pri");
    cyc(1,0,0,0,0,4'h0,32'hf, 0,0,5'h0d,4'h0,"pri_hnd");
    cyc(1,0,0,0,1,4'h0,32'hf, 1,1,5'h0d,4'h0,"pri_ret");
    cyc(1,0,0,0,0,4'h0,32'hf, 0,0,5'h0d,4'h0,"pri_idle");

    cyc(1,0,0,0,1,4'h0,32'hf, 1,1,5'h0d,4'h0,"eret_idle");
    cyc(1,0,0,0,0,4'h0,32'hf, 0,0,5'h0d,4'h0,"eret_back");

    cyc(1,0,1,0,0,4'h0,32'hb, 0,0,5'h0d,4'h0,"brk_masked");
    cyc(1,0,1,0,0,4'h0,32'hf, 1,0,5'h09,4'h0,"brk");
    cyc(1,0,0,0,0,4'h0,32'hf, 0,0,5'h09,4'h0,"brk_hnd");
    cyc(1,0,0,0,1,4'h0,32'hf, 1,1,5'h09,4'h0,"brk_ret");
    cyc(1,0,0,0,0,4'h0,32'hf, 0,0,5'h09,4'h0,"brk_idle");

    for (int i = 1; i <= 3; i++)
      cyc(1,0,0,0,0, (i == 1) ? 4'b0110 : 4'b0000, 32'h1,
          0,0,5'h09, (i >= LAT) ? 4'b0110 : 4'b0000,
          "irq_fill");
    cyc(1,0,0,0,0,4'h0,32'hf01, 1,0,5'h00,4'b0100,"irq1_take");
    cyc(1,0,0,0,0,4'h0,32'hf01, 0,0,5'h00,4'b0100,"irq_hnd");
    cyc(1,0,0,0,1,4'h0,32'hf01, 1,1,5'h00,4'b0100,"irq_ret");
    cyc(1,0,0,0,0,4'h0,32'hf01, 0,0,5'h00,4'b0100,"irq_idle");
    cyc(1,0,0,0,0,4'h0,32'hf01, 1,0,5'h00,4'b0000,"irq2_take");
    cyc(1,0,0,0,0,4'h0,32'hf01, 0,0,5'h00,4'b0000,"irq2_hnd");
    cyc(1,0,0,0,1,4'h0,32'hf01, 1,1,5'h00,4'b0000,"irq2_ret");
    cyc(1,0,0,0,0,4'h0,32'hf01, 0,0,5'h00,4'b0000,"irq2_idle");

    cyc(1,1,0,0,0,4'h0,32'hf, 1,0,5'h08,4'h0,"sys2");
    cyc(1,0,0,0,0,4'h0,32'hf, 0,0,5'h08,4'h0,"sys2_hnd");
    cyc(1,0,0,0,1,4'h0,32'hf, 1,1,5'h08,4'h0,"sys2_ret");
    cyc(1,0,0,0,0,4'h0,32'hf, 0,0,5'h08,4'h0,"sys2_idle");
    for (int i = 1; i <= 3; i++)
      cyc(1, (i == 1), 0,0,0, (i == 1) ? 4'b0001 : 4'b0000,
          32'he, 0,0,5'h08, (i >= LAT) ? 4'b0001 : 4'b0000,
          "ie_off");
    cyc(1,0,0,0,0,4'h0,32'h101, 1,0,5'h00,4'h0,"ie_on_irq0");
    cyc(1,0,0,0,0,4'h0,32'h101, 0,0,5'h00,4'h0,"ie_hnd");
    cyc(1,0,0,0,1,4'h0,32'h101, 1,1,5'h00,4'h0,"ie_ret");
    cyc(1,0,0,0,0,4'h0,32'h101, 0,0,5'h00,4'h0,"ie_idle");

    for (int i = 1; i <= LAT + 2; i++)
      cyc(1,0,0,0,0,4'b0001,32'h101,
          (i == LAT + 1), 0, 5'h00,
          (i >= LAT) ? 4'b0001 : 4'b0000, "set_wins");
    cyc(1,0,0,0,1,4'h0,32'h101, 1,1,5'h00,4'b0001,"sw_ret");
    cyc(1,0,0,0,0,4'h0,32'h101, 0,0,5'h00,4'b0001,"sw_idle");
    cyc(1,0,0,0,0,4'h0,32'h101, 1,0,5'h00,4'b0000,"sw_retake");
    cyc(1,0,0,0,0,4'h0,32'h101, 0,0,5'h00,4'b0000,"sw_hnd");
    cyc(1,0,0,0,1,4'h0,32'h101, 1,1,5'h00,4'b0000,"sw_ret2");
    cyc(1,0,0,0,0,4'h0,32'h101, 0,0,5'h00,4'b0000,"sw_idle2");

    cyc(1,1,0,0,0,4'h0,32'hf, 1,0,5'h08,4'h0,"sys_pre_rst");
    cyc(0,0,0,0,0,4'h0,32'hf, 0,0,5'h00,4'h0,"rst_mid");
    cyc(1,0,0,0,0,4'h0,32'hf, 0,0,5'h00,4'h0,"post_rst");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
